// File: rtl/ddr_pkg.sv
// Shared constants and FSM encoding for the arrow-scroll playfield.
package ddr_pkg;
    localparam int CORDW       = 10;
    localparam int ARROW_COUNT = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;
endpackage

// File: rtl/btn_edge.sv
// Per-bit rising-edge detector; history loads the live inputs during reset so
// a button held through reset produces no edge afterwards.
module btn_edge #(
    parameter int W = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] rise
);
    logic [W-1:0] hist;

    always_ff @(posedge clk_i) begin
        hist <= btn_i;
    end

    assign rise = btn_i & ~hist & {W{~rst_i}};
endmodule

// File: rtl/arrow_scroll.sv
// Rhythm-game arrow lanes: spawn, per-frame upward scroll swept one lane per
// cycle, button hit judgement against a target line, and a saturating score.
module arrow_scroll
    import ddr_pkg::*;
#(
    parameter int CORDW       = ddr_pkg::CORDW,
    parameter int ARROW_COUNT = ddr_pkg::ARROW_COUNT,
    parameter int SPAWN_Y     = 479,
    parameter int SPEED       = 2,
    parameter int TARGET_Y    = 40,
    parameter int HIT_WIN     = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         frame_i,
    input  logic                         spawn_valid_i,
    input  logic [ARROW_COUNT-1:0]       spawn_lane_i,
    output logic                         spawn_ready_o,
    input  logic [ARROW_COUNT-1:0]       btn_i,
    output logic [CORDW*ARROW_COUNT-1:0] arrow_y_o,
    output logic [ARROW_COUNT-1:0]       arrow_active_o,
    output logic [ARROW_COUNT-1:0]       hit_o,
    output logic [ARROW_COUNT-1:0]       miss_o,
    output logic [15:0]                  score_o
);
    localparam int LW = (ARROW_COUNT > 1) ? $clog2(ARROW_COUNT) : 1;
    localparam logic [CORDW-1:0] PARK   = '1;
    localparam logic [31:0]      WIN_LO = 32'(TARGET_Y - HIT_WIN);
    localparam logic [31:0]      WIN_HI = 32'(TARGET_Y + HIT_WIN);
    // Lowest y that can still take a full step without leaving the window.
    localparam logic [31:0]      MOVE_MIN = 32'(TARGET_Y - HIT_WIN + SPEED);

    state_t state, state_n;
    logic [LW-1:0] lane, lane_n;

    logic [ARROW_COUNT-1:0][CORDW-1:0] y_q, y_n;
    logic [ARROW_COUNT-1:0] act_q, act_n, hit_q, hit_n, miss_q, miss_n;
    logic [ARROW_COUNT-1:0] pend_q, pend_n, rise;
    logic [15:0] score_q, score_n;
    logic [16:0] sum;
    logic        ready_q;

    btn_edge #(.W(ARROW_COUNT)) u_btn_edge (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .btn_i (btn_i),
        .rise  (rise)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            lane  <= '0;
        end else begin
            state <= state_n;
            lane  <= lane_n;
        end
    end

    always_comb begin
        state_n = state;
        lane_n  = lane;
        case (state)
            IDLE: if (frame_i) begin
                state_n = UPDATE;
                lane_n  = '0;
            end
            UPDATE: if (lane == LW'(ARROW_COUNT - 1)) begin
                state_n = IDLE;
                lane_n  = '0;
            end else begin
                lane_n = lane + LW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        y_n    = y_q;
        act_n  = act_q;
        hit_n  = '0;
        miss_n = '0;
        pend_n = pend_q | rise;
        if (state == IDLE) begin
            // Hits resolve first so a same-cycle spawn on that lane is dropped.
            pend_n = rise;
            for (int k = 0; k < ARROW_COUNT; k++) begin
                if (pend_q[k] && act_q[k] && 32'(y_q[k]) >= WIN_LO && 32'(y_q[k]) <= WIN_HI) begin
                    hit_n[k] = 1'b1;
                    act_n[k] = 1'b0;
                    y_n[k]   = PARK;
                end
            end
            if (spawn_valid_i) begin
                for (int k = 0; k < ARROW_COUNT; k++) begin
                    if (spawn_lane_i[k] && !act_q[k] && !hit_n[k]) begin
                        act_n[k] = 1'b1;
                        y_n[k]   = CORDW'(SPAWN_Y);
                    end
                end
            end
        end else begin
            for (int k = 0; k < ARROW_COUNT; k++) begin
                if (lane == LW'(k) && act_q[k]) begin
                    if (32'(y_q[k]) >= MOVE_MIN) begin
                        y_n[k] = y_q[k] - CORDW'(SPEED);
                    end else begin
                        act_n[k]  = 1'b0;
                        y_n[k]    = PARK;
                        miss_n[k] = 1'b1;
                    end
                end
            end
        end
        sum = {1'b0, score_q};
        for (int k = 0; k < ARROW_COUNT; k++) sum = sum + 17'(hit_n[k]);
        score_n = sum[16] ? 16'hFFFF : sum[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            y_q     <= '1;
            act_q   <= '0;
            hit_q   <= '0;
            miss_q  <= '0;
            pend_q  <= '0;
            score_q <= '0;
            ready_q <= 1'b1;
        end else begin
            y_q     <= y_n;
            act_q   <= act_n;
            hit_q   <= hit_n;
            miss_q  <= miss_n;
            pend_q  <= pend_n;
            score_q <= score_n;
            ready_q <= (state_n == IDLE);
        end
    end

    assign arrow_y_o      = y_q;
    assign arrow_active_o = act_q;
    assign hit_o          = hit_q;
    assign miss_o         = miss_q;
    assign score_o        = score_q;
    assign spawn_ready_o  = ready_q;
endmodule

// File: tb/tb_arrow_scroll.sv
// Directed bench for arrow_scroll: scroll/miss, hits, pending-during-sweep,
// score saturation and reset mid-sweep.
module tb_arrow_scroll;
    localparam int N  = 3;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame = 1'b0;
    logic          spawn_valid = 1'b0;
    logic [N-1:0]  spawn_lane = '0;
    logic          spawn_ready;
    logic [N-1:0]  btn = '0;
    logic [CW*N-1:0] arrow_y;
    logic [N-1:0]  arrow_active, hit, miss;
    logic [15:0]   score;

    int tests = 0;
    int fails = 0;
    int hit_cnt[N];
    int miss_cnt[N];
    int h0, m0;

    arrow_scroll dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .frame_i        (frame),
        .spawn_valid_i  (spawn_valid),
        .spawn_lane_i   (spawn_lane),
        .spawn_ready_o  (spawn_ready),
        .btn_i          (btn),
        .arrow_y_o      (arrow_y),
        .arrow_active_o (arrow_active),
        .hit_o          (hit),
        .miss_o         (miss),
        .score_o        (score)
    );

    always #5 clk = ~clk;

    initial begin
        for (int k = 0; k < N; k++) begin
            hit_cnt[k]  = 0;
            miss_cnt[k] = 0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (hit[k])  hit_cnt[k]  = hit_cnt[k] + 1;
            if (miss[k]) miss_cnt[k] = miss_cnt[k] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ly(input int k);
        return 32'(arrow_y[k*CW +: CW]);
    endfunction

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame = 1'b1;
            tick();
            frame = 1'b0;
            repeat (N + 1) tick();
        end
    endtask

    task automatic spawn(input logic [N-1:0] mask);
        int w = 0;
        spawn_valid = 1'b1;
        spawn_lane  = mask;
        while (!spawn_ready && w < 20) begin
            tick();
            w++;
        end
        chk("spawn_ready", 32'(spawn_ready), 32'd1);
        tick();
        spawn_valid = 1'b0;
        spawn_lane  = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        rst = 1'b0;
        chk("rst_y",     32'(arrow_y), 32'h3FFF_FFFF);
        chk("rst_act",   32'(arrow_active), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_ready", 32'(spawn_ready), 32'd1);
        chk("rst_hitmiss", {hit, miss}, 32'd0);

        // Scroll to y=47, then fall out of the window and miss.
        spawn(3'b001);
        chk("spawn_y0",  ly(0), 32'd479);
        chk("spawn_act", 32'(arrow_active), 32'b001);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        chk("lat_t1", ly(0), 32'd479);
        tick();
        chk("lat_t2", ly(0), 32'd477);
        repeat (N - 1) tick();
        frames(215);
        chk("y0_47",   ly(0), 32'd47);
        chk("act_47",  32'(arrow_active), 32'b001);
        frames(7);
        chk("y0_33",   ly(0), 32'd33);
        chk("no_miss_yet", 32'(miss_cnt[0]), 32'd0);
        frames(1);
        chk("miss_cnt0", 32'(miss_cnt[0]), 32'd1);
        chk("miss_y0",   ly(0), 32'd1023);
        chk("miss_act",  32'(arrow_active), 32'd0);

        // Single hit at y=39.
        spawn(3'b001);
        frames(220);
        chk("y0_39", ly(0), 32'd39);
        btn = 3'b001;
        tick();
        chk("hit_early", 32'(hit), 32'd0);
        tick();
        chk("hit1",   32'(hit), 32'b001);
        chk("score1", 32'(score), 32'd1);
        chk("hit1_y", ly(0), 32'd1023);
        tick();
        chk("hit1_pulse", 32'(hit), 32'd0);
        btn = '0;
        tick();

        // Three simultaneous hits.
        spawn(3'b111);
        frames(220);
        chk("y_all", 32'(arrow_y), {2'b0, 10'd39, 10'd39, 10'd39});
        btn = 3'b111;
        repeat (2) tick();
        chk("hit3",   32'(hit), 32'b111);
        chk("score4", 32'(score), 32'd4);
        chk("act3",   32'(arrow_active), 32'd0);
        btn = '0;
        tick();

        // Press during the sweep stays pending until IDLE.
        spawn(3'b001);
        frames(219);
        chk("y0_41", ly(0), 32'd41);
        frame = 1'b1;
        tick();
        frame = 1'b0;
        btn = 3'b001;
        repeat (3) tick();
        chk("sweep_nohit", 32'(hit), 32'd0);
        chk("sweep_y0",    ly(0), 32'd39);
        tick();
        chk("sweep_hit",   32'(hit), 32'b001);
        chk("score5",      32'(score), 32'd5);
        btn = '0;
        tick();

        // Out-of-window press is discarded.
        spawn(3'b001);
        frames(190);
        h0 = hit_cnt[0];
        btn = 3'b001;
        repeat (4) tick();
        btn = '0;
        tick();
        chk("far_nohit", 32'(hit_cnt[0] - h0), 32'd0);
        chk("far_y0",    ly(0), 32'd99);
        chk("far_act",   32'(arrow_active), 32'b001);
        chk("far_score", 32'(score), 32'd5);

        // Saturation: two hits on top of FFFE.
        spawn(3'b110);
        frames(220);
        force dut.score_q = 16'hFFFE;
        tick();
        release dut.score_q;
        btn = 3'b110;
        repeat (2) tick();
        chk("sat_hit",   32'(hit), 32'b110);
        chk("sat_score", 32'(score), 32'hFFFF);
        btn = '0;
        tick();

        // Reset in the middle of a sweep that would otherwise miss all lanes.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        spawn(3'b111);
        frames(223);
        m0 = miss_cnt[0] + miss_cnt[1] + miss_cnt[2];
        h0 = hit_cnt[0] + hit_cnt[1] + hit_cnt[2];
        frame = 1'b1;
        tick();
        frame = 1'b0;
        rst = 1'b1;
        btn = 3'b111;
        tick();
        rst = 1'b0;
        repeat (6) tick();
        chk("rstmid_miss",  32'(miss_cnt[0] + miss_cnt[1] + miss_cnt[2] - m0), 32'd0);
        chk("rstmid_hit",   32'(hit_cnt[0] + hit_cnt[1] + hit_cnt[2] - h0), 32'd0);
        chk("rstmid_y",     32'(arrow_y), 32'h3FFF_FFFF);
        chk("rstmid_act",   32'(arrow_active), 32'd0);
        chk("rstmid_score", 32'(score), 32'd0);
        chk("rstmid_ready", 32'(spawn_ready), 32'd1);
        btn = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
